// File: rtl/oled_pattern_scheduler.sv
// Frame-synchronous test-pattern scheduler for the OLED video path.
// Rotates among four RGB565 patterns on a dwell timer or a manual advance, switching only at frame wraps.
module oled_pattern_scheduler #(
  parameter int C_x_max        = 127,
  parameter int C_y_max        = 159,
  parameter int C_dwell_frames = 60
) (
  input  logic        clk,
  input  logic        resn,
  input  logic [6:0]  x,
  input  logic [7:0]  y,
  input  logic        advance,
  input  logic        auto_en,
  output logic [15:0] color,
  output logic [1:0]  pattern,
  output logic        frame_tick
);

  localparam logic [6:0] X_MAX      = 7'(C_x_max);
  localparam logic [7:0] Y_MAX      = 8'(C_y_max);
  localparam logic [7:0] DWELL_LAST = 8'(C_dwell_frames - 1);

  typedef enum logic {S_HOLD, S_PENDING} state_t;

  state_t      state, state_nxt;
  logic [6:0]  x_prev;
  logic [7:0]  y_prev;
  logic        adv_meta, adv_sync, adv_last;
  logic [7:0]  dwell, dwell_nxt;
  logic [4:0]  anim, anim_nxt;
  logic [1:0]  pattern_nxt;
  logic [15:0] color_nxt;
  logic        wrap, adv_edge, manual_step, auto_step;

  // A wrap is the first cycle the scan moves away from the last pixel of the frame.
  assign wrap        = (x_prev == X_MAX) && (y_prev == Y_MAX) && ((x != x_prev) || (y != y_prev));
  assign adv_edge    = adv_sync & ~adv_last;
  assign manual_step = (state == S_PENDING) || adv_edge;
  assign auto_step   = auto_en && (dwell == DWELL_LAST);

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      x_prev   <= '0;
      y_prev   <= '0;
      adv_meta <= 1'b0;
      adv_sync <= 1'b0;
      adv_last <= 1'b0;
    end else begin
      x_prev   <= x;
      y_prev   <= y;
      adv_meta <= advance;
      adv_sync <= adv_meta;
      adv_last <= adv_sync;
    end
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state      <= S_HOLD;
      pattern    <= '0;
      dwell      <= '0;
      anim       <= '0;
      frame_tick <= 1'b0;
      color      <= '0;
    end else begin
      state      <= state_nxt;
      pattern    <= pattern_nxt;
      dwell      <= dwell_nxt;
      anim       <= anim_nxt;
      frame_tick <= wrap;
      color      <= color_nxt;
    end
  end

  // Manual and auto switches landing on the same wrap merge into a single step.
  always_comb begin
    state_nxt   = state;
    pattern_nxt = pattern;
    dwell_nxt   = dwell;
    anim_nxt    = anim;
    if (wrap) begin
      anim_nxt  = anim + 5'd1;
      state_nxt = S_HOLD;
      if (manual_step || auto_step) begin
        pattern_nxt = pattern + 2'd1;
        dwell_nxt   = '0;
      end else if (auto_en) begin
        dwell_nxt = dwell + 8'd1;
      end
    end else if (adv_edge) begin
      state_nxt = S_PENDING;
    end
    if (!auto_en) dwell_nxt = '0;
  end

  // Built from the post-wrap pattern/anim so the second cycle of pixel (0,0) already shows the new frame.
  always_comb begin
    color_nxt = '0;
    unique case (pattern_nxt)
      2'd0: color_nxt = (x[3] ^ y[3]) ? 16'h07E0 : 16'hF800;
      2'd1: begin
        unique case (x[6:4])
          3'd0: color_nxt = 16'hFFFF;
          3'd1: color_nxt = 16'hFFE0;
          3'd2: color_nxt = 16'h07FF;
          3'd3: color_nxt = 16'h07E0;
          3'd4: color_nxt = 16'hF81F;
          3'd5: color_nxt = 16'hF800;
          3'd6: color_nxt = 16'h001F;
          3'd7: color_nxt = 16'h0000;
        endcase
      end
      2'd2: color_nxt = {y[7:3], x[6:1], anim_nxt};
      2'd3: color_nxt = {anim_nxt, 6'd0, ~anim_nxt};
    endcase
  end

endmodule
